// File: rtl/seven_seg_scan.sv
// Seven-segment driver: hex/BCD decode, leading-zero blanking, static and scanned outputs.
// Outputs are registered with one clock from digit register/mode inputs; there is no backpressure.
module seven_seg_scan #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_input,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [7*DIGITS-1:0]   data_output,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int TW = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IW = (DIGITS > 1)    ? $clog2(DIGITS)    : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]    SEG_BLANK  = 7'h7F;

  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [BW-1:0]       blink_q, blink_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                phase_q, phase_d;
  logic [7*DIGITS-1:0] data_q, data_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [6:0]          dec [DIGITS];
  logic                tick;
  logic                leading;

  function automatic logic [6:0] seg_decode(input logic [3:0] v, input logic hex);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    // Non-decimal nibbles in BCD mode show a dash.
    if (!hex && v > 4'h9) s = 7'h3F;
    return s;
  endfunction

  always_comb begin
    leading = blank_lz;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dec[i] = seg_decode(digits_q[4*i +: 4], hex_mode);
      if (leading && i != 0 && digits_q[4*i +: 4] == 4'h0) begin
        dec[i] = SEG_BLANK;
      end else begin
        leading = 1'b0;
      end
    end
  end

  always_comb begin
    data_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      data_d[7*i +: 7] = dec[i];
    end
    seg_d = (blink_en && phase_q) ? SEG_BLANK : dec[idx_q];
    sel_d = ~(DIGITS'(1) << idx_q);
  end

  always_comb begin
    tick     = (tick_q == TICK_LAST);
    digits_d = load ? data_input : digits_q;
    tick_d   = tick ? '0 : tick_q + 1'b1;
    idx_d    = idx_q;
    blink_d  = blink_q;
    phase_d  = phase_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      tick_q   <= '0;
      blink_q  <= '0;
      idx_q    <= '0;
      phase_q  <= 1'b0;
      data_q   <= {DIGITS{SEG_BLANK}};
      seg_q    <= SEG_BLANK;
      sel_q    <= '1;
    end else begin
      digits_q <= digits_d;
      tick_q   <= tick_d;
      blink_q  <= blink_d;
      idx_q    <= idx_d;
      phase_q  <= phase_d;
      data_q   <= data_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
    end
  end

  assign data_output = data_q;
  assign seg_out     = seg_q;
  assign dig_sel     = sel_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: two instances (SCAN_DIV=4 and SCAN_DIV=1) share stimulus;
// a cycle model queues expected outputs per edge, plus directed constant checks.
module tb_seven_seg_scan;

  localparam int SD[2] = '{4, 1};
  localparam int BD    = 2;

  logic        clk = 1'b0;
  logic        rst_n, load, hex_mode, blank_lz, blink_en;
  logic [15:0] data_input;
  logic [27:0] data_a, data_b;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  sel_a, sel_b;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [27:0] d;
    logic [6:0]  s;
    logic [3:0]  sel;
  } exp_t;

  exp_t        qa[$], qb[$];
  logic [15:0] mdig[2];
  int          mi[2], mt[2], mb[2];
  bit          mph[2];

  always #5 clk = ~clk;

  seven_seg_scan #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(BD)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_input(data_input), .load(load),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .blink_en(blink_en),
    .data_output(data_a), .seg_out(seg_a), .dig_sel(sel_a));

  seven_seg_scan #(.DIGITS(4), .SCAN_DIV(1), .BLINK_DIV(BD)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_input(data_input), .load(load),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .blink_en(blink_en),
    .data_output(data_b), .seg_out(seg_b), .dig_sel(sel_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] v, input logic hx);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: begin
        if (!hx) return 7'h3F;
        case (v)
          4'hA: return 7'h08;
          4'hB: return 7'h03;
          4'hC: return 7'h46;
          4'hD: return 7'h21;
          4'hE: return 7'h06;
          default: return 7'h0E;
        endcase
      end
    endcase
  endfunction

  // Digits above the most significant nonzero digit are blanked when blank_lz is set.
  function automatic logic [27:0] dec_all(input logic [15:0] w, input logic hx, input logic bz);
    logic [27:0] r;
    int top;
    top = 0;
    for (int i = 0; i < 4; i++) if (w[4*i +: 4] != 4'h0) top = i;
    for (int i = 0; i < 4; i++) r[7*i +: 7] = (bz && i > top) ? 7'h7F : seg7(w[4*i +: 4], hx);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mdig[k] = '0; mi[k] = 0; mt[k] = 0; mb[k] = 0; mph[k] = 1'b0;
      end
      qa.delete();
      qb.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_t        e;
        logic [27:0] all;
        all   = dec_all(mdig[k], hex_mode, blank_lz);
        e.d   = all;
        e.s   = (blink_en && mph[k]) ? 7'h7F : all[7*mi[k] +: 7];
        e.sel = 4'hF & ~(4'b0001 << mi[k]);
        if (k == 0) qa.push_back(e); else qb.push_back(e);
        if (load) mdig[k] = data_input;
        if (mt[k] == SD[k] - 1) begin
          mt[k] = 0;
          mi[k] = (mi[k] + 1) % 4;
          if (mb[k] == BD - 1) begin
            mb[k]  = 0;
            mph[k] = !mph[k];
          end else begin
            mb[k] = mb[k] + 1;
          end
        end else begin
          mt[k] = mt[k] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_data", data_a, e.d);
      chk("a_seg", seg_a, e.s);
      chk("a_sel", sel_a, e.sel);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_data", data_b, e.d);
      chk("b_seg", seg_b, e.s);
      chk("b_sel", sel_b, e.sel);
    end
  end

  task automatic load_word(input logic [15:0] w);
    load       = 1'b1;
    data_input = w;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_data_a"}, data_a, {4{7'h7F}});
    chk({tag, "_seg_a"}, seg_a, 7'h7F);
    chk({tag, "_sel_a"}, sel_a, 4'hF);
    chk({tag, "_data_b"}, data_b, {4{7'h7F}});
    chk({tag, "_seg_b"}, seg_b, 7'h7F);
    chk({tag, "_sel_b"}, sel_b, 4'hF);
  endtask

  initial begin
    int cnt[4];
    int nblank;
    int nidx;
    rst_n = 1'b1; load = 1'b0; data_input = '0;
    hex_mode = 1'b0; blank_lz = 1'b0; blink_en = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_reset("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_data", data_a, {4{7'h40}});
    chk("rel_sel", sel_a, 4'b1110);
    chk("rel_seg", seg_a, 7'h40);

    load_word(16'h1279);
    chk("bcd_1279", data_a, {7'h79, 7'h24, 7'h78, 7'h10});
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (sel_a == (4'hF & ~(4'b0001 << i))) cnt[i]++;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("scan_hold%0d", i), cnt[i], 4);

    load_word(16'h00A0);
    chk("bcd_dash", data_a, {7'h40, 7'h40, 7'h3F, 7'h40});
    hex_mode = 1'b1; blank_lz = 1'b1;
    @(negedge clk);
    chk("hex_lz", data_a, {7'h7F, 7'h7F, 7'h08, 7'h40});
    load_word(16'h0000);
    chk("all_zero_lz", data_a, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    hex_mode = 1'b0;
    load_word(16'h0B03);
    chk("dash_nonzero", data_a, {7'h7F, 7'h3F, 7'h40, 7'h30});
    hex_mode = 1'b1; blank_lz = 1'b0;
    load_word(16'hFEDC);
    chk("hex_fedc", data_a, {7'h0E, 7'h06, 7'h21, 7'h46});

    hex_mode = 1'b0;
    load_word(16'h1279);
    blink_en = 1'b1;
    @(negedge clk);
    nblank = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (seg_b == 7'h7F) nblank++;
    end
    chk("blink_count", nblank, 4);
    chk("blink_data", data_b, {7'h79, 7'h24, 7'h78, 7'h10});
    blink_en = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 40 && mt[0] != 3; i++) @(negedge clk);
    chk("wait_tick", mt[0] == 3, 1'b1);
    nidx = (mi[0] + 1) % 4;
    load = 1'b1; data_input = 16'h1111;
    @(negedge clk);
    data_input = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    chk("tickload_seg1", seg_a, 7'h79);
    chk("tickload_sel", sel_a, 4'hF & ~(4'b0001 << nidx));
    @(negedge clk);
    chk("tickload_seg2", seg_a, 7'h24);
    chk("tickload_data", data_a, {4{7'h24}});

    for (int i = 0; i < 40 && !(mi[0] == 2 && mt[0] == 2); i++) @(negedge clk);
    chk("wait_mid", (mi[0] == 2 && mt[0] == 2), 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_data", data_a, {4{7'h40}});
    chk("midrst_sel0", sel_a, 4'b1110);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("midrst_hold%0d", c), sel_a, 4'b1110);
    end
    @(negedge clk);
    chk("midrst_next", sel_a, 4'b1101);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, registered seven-segment display driver for DIGITS nibble-coded digits. It captures a packed digit word on a load strobe and decodes it in hex or BCD mode, with defined codes for invalid BCD digits and optional leading-zero blanking. It drives both a static per-digit segment bus and a time-multiplexed scan interface (one segment bus plus digit selects) with optional blink. It sits between the datapath/result registers and the board display pins.

## Interface
- DIGITS, 4: number of digits; legal 1..8.
- SCAN_DIV, 50000: clocks per digit in the scan; legal ≥1.
- BLINK_DIV, 64: scan ticks per blink half-period; legal ≥1.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_input  in  4*DIGITS  packed digits; digit i = data_input[4i+3:4i]; digit 0 is least significant.
- load  in  1  capture data_input into the internal digit register.
- hex_mode  in  1  1 = hex decode 0-F; 0 = BCD decode (A-F invalid).
- blank_lz  in  1  1 = blank leading zero digits.
- blink_en  in  1  1 = scan output blinks.
- data_output  out  7*DIGITS  static segments; digit i = data_output[7i+6:7i].
- seg_out  out  7  scanned segments for the selected digit.
- dig_sel  out  DIGITS  scanned digit enables; active-low, one-hot-zero.

## Operation
- Segment encoding: active-low, bit order {g,f,e,d,c,b,a}.
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - A=08, b=03, C=46, d=21, E=06, F=0E.
  - Blank=7F, dash=3F.
- BCD mode with a digit value A-F: that digit shows dash (3F). Hex mode never produces dash.
- Digit register (4*DIGITS bits):
  - Loads data_input on a clock edge where load=1; holds otherwise.
  - Reset value: 0.
- Leading-zero blanking (blank_lz=1):
  - Starting from digit DIGITS-1 downward, each zero digit is blanked (7F) until the first nonzero digit.
  - Digit 0 is never blanked, so an all-zero value shows a single "0".
  - A dash digit counts as nonzero.
- hex_mode, blank_lz and blink_en are live: sampled every cycle, not captured by load.
- data_output:
  - Registered decode of the digit register, updated every clock.
  - Unaffected by blink.
- Scan:
  - tick_cnt counts 0..SCAN_DIV-1. A tick occurs on the cycle where tick_cnt = SCAN_DIV-1, and tick_cnt then returns to 0.
  - On each tick, digit index idx increments and wraps from DIGITS-1 to 0.
  - DIGITS=1: idx stays 0.
  - SCAN_DIV=1: a tick occurs every clock.
- Blink:
  - blink_cnt counts ticks 0..BLINK_DIV-1. On wrap, phase toggles.
  - phase reset value: 0 (visible).
  - blink_en=1 and phase=1: seg_out=7F, while dig_sel keeps scanning.
  - blink_en=0: seg_out is never blanked; counters keep running.
- seg_out / dig_sel:
  - Registered every clock from the current idx, digit register, and live mode inputs.
  - dig_sel has bit idx = 0 and all other bits = 1.

## Timing
- Reset (asynchronous assert; deassert synchronous to clk):
  - digit register = 0, idx = 0, tick_cnt = 0, blink_cnt = 0, phase = 0.
  - data_output = all 7F.
  - seg_out = 7F.
  - dig_sel = all ones (no digit lit).
- First edge after reset release: data_output shows the decoded zero register, and dig_sel/seg_out show digit 0.
- Load latency:
  - load sampled high at edge k: register updated at edge k.
  - data_output and seg_out (if the loaded digit is selected) reflect the new value at edge k+1.
- Mode-input latency: one clock to data_output and seg_out.
- A load coinciding with a tick: both take effect. At edge k+1, seg_out shows the new value of the new idx.
- Back-to-back loads: the last load wins. No load is dropped.
- Reset mid-scan: all state returns to reset values immediately. The scan restarts at digit 0 with a full SCAN_DIV period.
- idx advance: seg_out/dig_sel change exactly one clock after the tick cycle. Each digit is held SCAN_DIV clocks.

## Test plan
- Reset, DIGITS=4, SCAN_DIV=4:
  - Before the first edge: seg_out=7F, dig_sel=1111, data_output all 7F.
  - After release: data_output=40 on all digits with blank_lz=0.
- load 16'h1279, hex_mode=0, blank_lz=0 -> next edge data_output digits (3..0) = 79,24,78,10.
  - Scan: dig_sel 1110→1101→1011→0111, each held 4 clocks, then wraps.
  - seg_out matches data_output for the selected digit.
- load 16'h00A0:
  - hex_mode=0: digits = 40,40,3F,40.
  - hex_mode=1, blank_lz=1: digits = 7F,7F,08,40.
  - load 16'h0000 with blank_lz=1: digits = 7F,7F,7F,40.
- blink_en=1, SCAN_DIV=1, BLINK_DIV=2:
  - seg_out alternates between valid codes and 7F every 2 ticks.
  - dig_sel keeps rotating; data_output is unchanged.
- load asserted on the tick cycle, and again on the next cycle:
  - The final register holds the second value.
  - Two clocks later, seg_out decodes the new idx from the second value.
- rst_n pulsed low mid-scan (idx=2, tick_cnt=2): outputs return to reset values asynchronously, and the scan resumes at digit 0.
